// File: rtl/lcd_sfr_sequencer.sv
// HD44780 character-LCD sequencer on the DW8051 SFR bus.
// The CPU queues command/data bytes through SFR writes; a FIFO buffers them and a
// small FSM drives LCD_RS/LCD_EN/LCD_DATA with setup, pulse, hold and execution waits.
// Optional power-on init sequence: define LCD_INIT_SEQ_EN.
module lcd_sfr_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  ADDR_CMD   = 8'hF9,
  parameter logic [7:0]  ADDR_DAT   = 8'hFA,
  parameter logic [7:0]  ADDR_STAT  = 8'hFB,
  parameter logic [7:0]  ADDR_CTRL  = 8'hFC,
  parameter int unsigned T_SU       = 2,
  parameter int unsigned T_PW       = 25,
  parameter int unsigned T_H        = 2,
  parameter int unsigned T_SHORT    = 2000,
  parameter int unsigned T_LONG     = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  input  logic       sfr_wr,
  input  logic       sfr_rd,
  output logic [7:0] sfr_rdata,
  output logic       rd_hit,
  output logic [7:0] LCD_DATA,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_ON,
  output logic       LCD_BLON
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned T_INIT = 750000;
`else
  localparam int unsigned T_INIT = 0;
`endif

  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned T_MAX = max2(max2(max2(T_SU, T_PW), max2(T_H, T_SHORT)),
                                       max2(T_LONG, T_INIT));
  localparam int unsigned TW    = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {StIdle, StSetup, StEnHi, StHold, StWait, StInit} state_e;

  // Address decode and bus strobes
  logic hit_cmd, hit_dat, hit_stat, hit_ctrl;
  logic push, flush, push_ok, pop, stat_rd;
  logic fifo_full, fifo_empty;

  assign hit_cmd  = (sfr_addr == ADDR_CMD);
  assign hit_dat  = (sfr_addr == ADDR_DAT);
  assign hit_stat = (sfr_addr == ADDR_STAT);
  assign hit_ctrl = (sfr_addr == ADDR_CTRL);
  assign push     = sfr_wr & (hit_cmd | hit_dat);
  assign flush    = sfr_wr & hit_ctrl & sfr_wdata[1];
  assign stat_rd  = sfr_rd & hit_stat;
  // A flush swallows a coinciding push.
  assign push_ok  = push & ~fifo_full & ~flush;

  // FIFO state
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [8:0]    head;

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // FIFO storage, entry is {rs, byte}
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {hit_dat, sfr_wdata};
  end

  // FIFO pointers and occupancy; flush wins over everything else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop);
    end
  end

  // Overflow flag: a drop in the same cycle as a STAT read leaves it set
  logic ovf_q, ovf_d;
  always_comb begin
    ovf_d = (push & fifo_full & ~flush) | (ovf_q & ~stat_rd);
  end

  // Overflow and control registers
  logic lcd_on_q, blon_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q    <= 1'b0;
      lcd_on_q <= 1'b1;
      blon_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (sfr_wr && hit_ctrl) begin
        lcd_on_q <= sfr_wdata[0];
        blon_q   <= sfr_wdata[2];
      end
    end
  end

  // Power-on init ROM
  logic       init_pending;
  logic [7:0] init_byte;
`ifdef LCD_INIT_SEQ_EN
  logic [2:0] init_idx_q;
  logic       init_adv;
  assign init_pending = (init_idx_q != 3'd4);
  always_comb begin
    init_byte = 8'h00;
    unique case (init_idx_q)
      3'd0:    init_byte = 8'h38;
      3'd1:    init_byte = 8'h0C;
      3'd2:    init_byte = 8'h01;
      3'd3:    init_byte = 8'h06;
      default: init_byte = 8'h00;
    endcase
  end
  // Init ROM index, advances each time a ROM byte is launched
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           init_idx_q <= '0;
    else if (init_adv) init_idx_q <= init_idx_q + 3'd1;
  end
`else
  assign init_pending = 1'b0;
  assign init_byte    = 8'h00;
`endif

  // FSM and bus latches
  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] wait_len;
  logic          busy;

  // Clear/home commands need the long execution wait
  assign wait_len = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? TW'(T_LONG - 1)
                                                                     : TW'(T_SHORT - 1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef LCD_INIT_SEQ_EN
      state_q <= StInit;
      cnt_q   <= TW'(T_INIT - 1);
`else
      state_q <= StIdle;
      cnt_q   <= '0;
`endif
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic: each timed state runs for (loaded count + 1) cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    init_adv = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (init_pending) begin
`ifdef LCD_INIT_SEQ_EN
          init_adv = 1'b1;
`endif
          rs_d    = 1'b0;
          data_d  = init_byte;
          cnt_d   = TW'(T_SU - 1);
          state_d = StSetup;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          rs_d    = head[8];
          data_d  = head[7:0];
          cnt_d   = TW'(T_SU - 1);
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          cnt_d   = TW'(T_PW - 1);
          state_d = StEnHi;
        end else cnt_d = cnt_q - TW'(1);
      end
      StEnHi: begin
        if (cnt_q == '0) begin
          cnt_d   = TW'(T_H - 1);
          state_d = StHold;
        end else cnt_d = cnt_q - TW'(1);
      end
      StHold: begin
        if (cnt_q == '0) begin
          cnt_d   = wait_len;
          state_d = StWait;
        end else cnt_d = cnt_q - TW'(1);
      end
      StWait, StInit: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - TW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and latches
  always_comb begin
    LCD_EN   = (state_q == StEnHi);
    busy     = (state_q != StIdle) | init_pending;
    LCD_RS   = rs_q;
    LCD_DATA = data_q;
    LCD_RW   = 1'b0;
    LCD_ON   = lcd_on_q;
    LCD_BLON = blon_q;
  end

  // SFR read mux, combinational from address
  logic [3:0] cnt_disp;
  always_comb begin
    cnt_disp = (32'(count_q) > 32'd15) ? 4'd15 : 4'(count_q);
    rd_hit   = hit_stat | hit_ctrl;
    if (hit_stat)      sfr_rdata = {cnt_disp, 1'b0, ovf_q, fifo_full, busy};
    else if (hit_ctrl) sfr_rdata = {5'b0, blon_q, 1'b0, lcd_on_q};
    else               sfr_rdata = 8'h00;
  end

endmodule
